// File: rtl/image_stats_acc.sv
// First- and second-order statistics over one X/Y image pair for the SSIM datapath.
// Two-stage pipeline: stage 1 registers the pixels and their products, stage 2 accumulates them.
module image_stats_acc #(
  parameter int unsigned N_PIXELS = 784,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned SUM_W    = 18,
  parameter int unsigned SQ_W     = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [SUM_W-1:0]  sum_x,
  output logic [SUM_W-1:0]  sum_y,
  output logic [SQ_W-1:0]   sum_xx,
  output logic [SQ_W-1:0]   sum_yy,
  output logic [SQ_W-1:0]   sum_xy
);

  localparam int unsigned      PW       = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [PW-1:0]     s1_xx_q, s1_xx_d, s1_yy_q, s1_yy_d, s1_xy_q, s1_xy_d;
  logic [SUM_W-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [SQ_W-1:0]   sum_xx_q, sum_xx_d, sum_yy_q, sum_yy_d, sum_xy_q, sum_xy_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    s1_valid_d = 1'b0;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_xx_d    = s1_xx_q;
    s1_yy_d    = s1_yy_q;
    s1_xy_d    = s1_xy_q;
    sum_x_d    = sum_x_q;
    sum_y_d    = sum_y_q;
    sum_xx_d   = sum_xx_q;
    sum_yy_d   = sum_yy_q;
    sum_xy_d   = sum_xy_q;

    // Stage 2 runs independently of state so FLUSH absorbs the final pair;
    // the clear on start below takes priority over it.
    if (s1_valid_q) begin
      sum_x_d  = sum_x_q  + SUM_W'(s1_x_q);
      sum_y_d  = sum_y_q  + SUM_W'(s1_y_q);
      sum_xx_d = sum_xx_q + SQ_W'(s1_xx_q);
      sum_yy_d = sum_yy_q + SQ_W'(s1_yy_q);
      sum_xy_d = sum_xy_q + SQ_W'(s1_xy_q);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACCUM;
          count_d  = '0;
          s1_x_d   = '0;
          s1_y_d   = '0;
          s1_xx_d  = '0;
          s1_yy_d  = '0;
          s1_xy_d  = '0;
          sum_x_d  = '0;
          sum_y_d  = '0;
          sum_xx_d = '0;
          sum_yy_d = '0;
          sum_xy_d = '0;
        end
      end
      ACCUM: begin
        if (pix_valid) begin
          s1_valid_d = 1'b1;
          s1_x_d     = x_in;
          s1_y_d     = y_in;
          s1_xx_d    = PW'(x_in) * PW'(x_in);
          s1_yy_d    = PW'(y_in) * PW'(y_in);
          s1_xy_d    = PW'(x_in) * PW'(y_in);
          count_d    = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_xx_q    <= '0;
      s1_yy_q    <= '0;
      s1_xy_q    <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      sum_xx_q   <= '0;
      sum_yy_q   <= '0;
      sum_xy_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_xx_q    <= s1_xx_d;
      s1_yy_q    <= s1_yy_d;
      s1_xy_q    <= s1_xy_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      sum_xx_q   <= sum_xx_d;
      sum_yy_q   <= sum_yy_d;
      sum_xy_q   <= sum_xy_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign count  = count_q;
  assign sum_x  = sum_x_q;
  assign sum_y  = sum_y_q;
  assign sum_xx = sum_xx_q;
  assign sum_yy = sum_yy_q;
  assign sum_xy = sum_xy_q;

endmodule

// File: doc/image_stats_acc.md
# image_stats_acc

Accumulates first- and second-order statistics over one image pair for the SSIM datapath. Sits directly downstream of the two pixel-stream memories (reference image X, test image Y), which run in lockstep. The block consumes N_PIXELS aligned byte pairs and produces Σx, Σy, Σx², Σy² and Σxy. The SSIM arithmetic stage reads these sums after `done`.

## Interface
- `N_PIXELS`, 784: pixel pairs per image (28×28).
- `DATA_W`, 8: pixel width.
- `CNT_W`, 10: counter width, ≥ clog2(N_PIXELS+1).
- `SUM_W`, 18: width of Σx and Σy, = DATA_W + CNT_W.
- `SQ_W`, 26: width of Σx², Σy² and Σxy, = 2·DATA_W + CNT_W.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begins a new accumulation pass when the block is idle.
- `pix_valid`  in  1  `x_in`/`y_in` hold a valid pair this cycle. No back-pressure exists, so every valid pair in ACCUM is consumed.
- `x_in`  in  DATA_W  reference pixel, unsigned.
- `y_in`  in  DATA_W  test pixel, unsigned.
- `busy`  out  1  high in ACCUM, FLUSH and DONE.
- `done`  out  1  one-cycle pulse; sums are final.
- `count`  out  CNT_W  pairs accepted in the current pass.
- `sum_x`, `sum_y`  out  SUM_W  running sums.
- `sum_xx`, `sum_yy`, `sum_xy`  out  SQ_W  running sums of products.

## Operation
- Four states: IDLE, ACCUM, FLUSH, DONE.
- **IDLE**
  - `start`=1 clears `count`, all sums and the product pipeline, then enters ACCUM.
  - `pix_valid` is ignored in IDLE, including in the cycle `start` is sampled.
- **ACCUM**
  - Stage 1: each edge with `pix_valid`=1 registers x, y, x·x, y·y and x·y (each product 2·DATA_W), plus a stage-valid bit, and increments `count`.
  - Stage 2: on the next edge, adds the stage-1 terms into the sums when stage-valid=1.
  - Sums are zero-extended and unsigned. No overflow is possible at the stated widths.
  - When the accepted pair makes `count` = N_PIXELS, go to FLUSH.
- **FLUSH**
  - One cycle, for stage 2 to absorb the last pair.
  - `pix_valid` is ignored from FLUSH onward.
  - Go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then return to IDLE.
- `start` outside IDLE is ignored; no restart while busy.
- Outputs hold their final values in IDLE until the next accepted `start`.
- Gaps in `pix_valid` during ACCUM only stall counting; the pass does not time out.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, all sums 0, state IDLE, pipeline cleared.
- Reset acts immediately, including mid-pass. Partial results are discarded, and the block stays in IDLE after release until a new `start`.
- `start` sampled at edge k:
  - `busy`=1 from edge k.
  - The first pair can be accepted at edge k+1, which matches the upstream memory raising valid one cycle after `start`.
- Nth pair accepted at edge t:
  - `count`=N_PIXELS from edge t.
  - State is FLUSH at t, and all sums are final from edge t+1.
  - State is DONE with `done`=1 from edge t+1 to t+2.
  - `busy`=0 from edge t+2.
- Latency from the last accepted pair to `done` high: 1 edge.
- Minimum pass length: N_PIXELS + 3 cycles from `start`.

## Test plan
- All pairs x=255, y=255, `pix_valid` held high, N=784 → `sum_x`=`sum_y`=199920, `sum_xx`=`sum_yy`=`sum_xy`=50979600, `count`=784, one `done` pulse 1 edge after the 784th pair.
- x=i mod 256, y=0, N=784 → `sum_x`=98040, `sum_y`=0, `sum_xy`=0, `sum_yy`=0.
- N_PIXELS=4; pairs (1,4), (2,3), (3,2), (4,1) with 2-cycle `pix_valid` gaps between pairs → `sum_x`=`sum_y`=10, `sum_xx`=`sum_yy`=30, `sum_xy`=20, `done` only after the 4th pair.
- N=4; `pix_valid` high for 10 cycles with x=y=1 → `sum_x`=4 and `count`=4. Pairs 5–10 are ignored.
- N=4; assert `start` again in ACCUM, and `pix_valid` in the same cycle as the first `start` → the restart is ignored, the same-cycle pair is not counted, and results come from the 4 following pairs.
- N=4; assert `rst` for 1 cycle after 2 pairs → all outputs 0 immediately, `busy`=0, and no `done` until a new `start` plus 4 pairs produces the correct sums.
